// File: rtl/hall_pkg.sv
// Shared types, commutation table, FSM encoding and default constants
// for the Hall-sensor velocity estimator.
package hall_pkg;

  typedef logic [2:0] hall_t;
  typedef logic [2:0] hall_idx_t;

  localparam hall_idx_t BAD_IDX = 3'd7;

  // Forward commutation order; reverse rotation walks it backwards.
  localparam hall_t FWD_SEQ [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  localparam int unsigned DEF_PRESCALE      = 64;
  localparam logic [31:0] DEF_VEL_NUMERATOR = 32'd1_000_000;
  localparam logic [15:0] DEF_STALL_TICKS   = 16'hFFFF;
  localparam int unsigned DIV_STEPS         = 32;

  function automatic hall_idx_t hall_index(hall_t h);
    hall_idx_t idx;
    idx = BAD_IDX;
    for (int i = 0; i < 6; i++)
      if (FWD_SEQ[i] == h) idx = hall_idx_t'(i);
    return idx;
  endfunction

  function automatic hall_idx_t idx_next(hall_idx_t i);
    return (i == 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic hall_idx_t idx_prev(hall_idx_t i);
    return (i == 3'd0) ? 3'd5 : i - 3'd1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// 32-bit by 16-bit restoring radix-2 divider: one quotient bit per cycle,
// 32 cycles from start to a one-cycle done pulse.
module seq_divider
  import hall_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [31:0] quotient,
  output logic        done
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

  logic [31:0] shift;
  logic [15:0] rem;
  logic [15:0] dvsr;
  logic [5:0]  steps;
  logic        busy;

  logic [15:0] step_rem_in;
  logic        step_bit_in;
  logic [15:0] step_dvsr;
  logic [16:0] step_out;

  function automatic logic [16:0] div_step(logic [15:0] r, logic b, logic [15:0] d);
    logic [16:0] cur;
    cur = {r, b};
    if (cur >= {1'b0, d}) return {16'(cur - {1'b0, d}), 1'b1};
    else                  return {cur[15:0], 1'b0};
  endfunction

  // The first step is taken on the start cycle itself, so the quotient is
  // complete after 32 clock edges.
  always_comb begin
    step_rem_in = busy ? rem : 16'd0;
    step_bit_in = busy ? shift[31] : dividend[31];
    step_dvsr   = busy ? dvsr : divisor;
    step_out    = div_step(step_rem_in, step_bit_in, step_dvsr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift <= '0;
      rem   <= '0;
      dvsr  <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem   <= step_out[16:1];
        shift <= {dividend[30:0], step_out[0]};
        dvsr  <= divisor;
        steps <= 6'd1;
        busy  <= 1'b1;
      end else if (busy) begin
        rem   <= step_out[16:1];
        shift <= {shift[30:0], step_out[0]};
        steps <= steps + 6'd1;
        if (steps == LAST_STEP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = shift;

endmodule

// File: rtl/hall_velocity_estimator.sv
// Hall-sensor period measurement and velocity = VEL_NUMERATOR / period.
// Define HALL_DIRECTION_EN to accept reverse rotation and report direction.
module hall_velocity_estimator
  import hall_pkg::*;
#(
  parameter int unsigned PRESCALE      = DEF_PRESCALE,
  parameter logic [31:0] VEL_NUMERATOR = DEF_VEL_NUMERATOR,
  parameter logic [15:0] STALL_TICKS   = DEF_STALL_TICKS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  hall,
  output logic [15:0] actual_velocity,
  output logic        velocity_valid,
  output logic        direction,
  output logic        hall_fault
);

  localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  hall_t       sync1, sync2, last_hall;
  logic        primed, stalled;
  logic [TW-1:0] tick_cnt;
  logic        tick;
  logic [15:0] period_cnt, period_next, cap_period;
  logic [15:0] pending;
  logic        pending_valid;
  hall_idx_t   sync_idx, last_idx;
  logic        sync_bad, last_bad, fwd_move, legal_move;
  logic        hall_edge, illegal_edge, restart_edge, meas_edge, stall_hit;
  state_t      state, state_next;
  logic        div_start, div_done, stash, load_velocity;
  logic [15:0] div_divisor;
  logic [31:0] div_quotient;

  // NOTE: the synchronizer flops carry no reset; after release they already
  // hold the live sensor value, which primes last_hall on the first clock.
  always_ff @(posedge clk) begin
    sync1 <= hall;
    sync2 <= sync1;
  end

  assign tick = (PRESCALE <= 1) || (tick_cnt == TW'(PRESCALE - 1));

  always_comb begin
    sync_idx   = hall_index(sync2);
    last_idx   = hall_index(last_hall);
    sync_bad   = (sync_idx == BAD_IDX);
    last_bad   = (last_idx == BAD_IDX);
    fwd_move   = !sync_bad && !last_bad && (sync_idx == idx_next(last_idx));
`ifdef HALL_DIRECTION_EN
    legal_move = fwd_move ||
                 (!sync_bad && !last_bad && (sync_idx == idx_prev(last_idx)));
`else
    legal_move = fwd_move;
`endif
    hall_edge    = primed && (sync2 != last_hall);
    illegal_edge = hall_edge && (sync_bad || (!last_bad && !legal_move));
    restart_edge = hall_edge && !illegal_edge && (stalled || last_bad);
    meas_edge    = hall_edge && !illegal_edge && !stalled && !last_bad;
    period_next  = (tick && period_cnt != STALL_TICKS) ? period_cnt + 16'd1 : period_cnt;
    cap_period   = (period_next == 16'd0) ? 16'd1 : period_next;
    stall_hit    = !stalled && !hall_edge && (period_cnt != STALL_TICKS) &&
                   (period_next == STALL_TICKS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt   <= '0;
      period_cnt <= '0;
      last_hall  <= '0;
      primed     <= 1'b0;
      stalled    <= 1'b1;
      hall_fault <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (!primed) begin
        primed    <= 1'b1;
        last_hall <= sync2;
      end else if (hall_edge) begin
        last_hall <= sync2;
      end
      period_cnt <= hall_edge ? 16'd0 : period_next;
      // A fault also drops the timing reference, like a stall.
      if (illegal_edge) begin
        hall_fault <= 1'b1;
        stalled    <= 1'b1;
      end else if (restart_edge) begin
        stalled <= 1'b0;
      end else if (stall_hit) begin
        stalled <= 1'b1;
      end
    end
  end

`ifdef HALL_DIRECTION_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      direction <= 1'b1;
    else if (hall_edge && legal_move)  direction <= fwd_move;
  end
`else
  assign direction = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (meas_edge || pending_valid) state_next = DIVIDE;
      DIVIDE:  if (div_done) state_next = DONE;
      DONE:    state_next = (meas_edge || pending_valid) ? DIVIDE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    div_start     = 1'b0;
    div_divisor   = cap_period;
    stash         = 1'b0;
    load_velocity = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (meas_edge) begin
          div_start = 1'b1;
        end else if (pending_valid) begin
          div_start   = 1'b1;
          div_divisor = pending;
        end
      end
      DIVIDE: begin
        stash         = meas_edge;
        load_velocity = div_done;
      end
      default: ;
    endcase
  end

  // Only the newest edge seen during a division is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (stash) begin
      pending       <= cap_period;
      pending_valid <= 1'b1;
    end else if (div_start || stall_hit) begin
      pending_valid <= 1'b0;
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (VEL_NUMERATOR),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

  // Registered at the end of DIVIDE so value and pulse appear in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      actual_velocity <= '0;
      velocity_valid  <= 1'b0;
    end else if (stall_hit) begin
      actual_velocity <= '0;
      velocity_valid  <= 1'b1;
    end else if (load_velocity && !stalled) begin
      actual_velocity <= (div_quotient[31:16] != 16'd0) ? 16'hFFFF : div_quotient[15:0];
      velocity_valid  <= 1'b1;
    end else begin
      velocity_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hall_velocity_estimator.sv
// Scoreboard bench for hall_velocity_estimator: expected velocity and
// pulse cycle are queued at each edge and compared on every valid pulse.
module tb_hall_velocity_estimator;

  localparam logic [31:0] NUM   = 32'd1_000_000;
  localparam logic [15:0] STALL = 16'd3000;
  localparam int LAT      = 35;  // drive cycle -> pulse cycle (2 sync + E+33)
  localparam int LAT_PEND = 68;  // pending division finishing after the first

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  hall;
  logic [15:0] actual_velocity;
  logic        velocity_valid;
  logic        direction;
  logic        hall_fault;

  typedef struct {
    logic [15:0] vel;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int pushes = 0;

  hall_velocity_estimator #(
    .PRESCALE      (1),
    .VEL_NUMERATOR (NUM),
    .STALL_TICKS   (STALL)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .hall            (hall),
    .actual_velocity (actual_velocity),
    .velocity_valid  (velocity_valid),
    .direction       (direction),
    .hall_fault      (hall_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_vel(input int period);
    int unsigned q;
    q = NUM / 32'(period);
    return (q > 32'd65535) ? 16'hFFFF : 16'(q);
  endfunction

  task automatic expect_pulse(input logic [15:0] v, input int at);
    exp_t e;
    e.vel = v;
    e.cyc = at;
    sb.push_back(e);
    pushes++;
  endtask

  task automatic edge_after(input int gap, input logic [2:0] v, output int d);
    repeat (gap) @(negedge clk);
    hall = v;
    d = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vel"},   actual_velocity, 0);
    check({tag, "_valid"}, velocity_valid, 0);
    check({tag, "_dir"},   direction, 1);
    check({tag, "_fault"}, hall_fault, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (velocity_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check("velocity", actual_velocity, e.vel);
          check("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int d, d4, d6;
    reset_n = 1'b0;
    hall    = 3'b001;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Forward rotation: first edge only restarts, then measurements.
    edge_after(5, 3'b011, d);
    edge_after(1000, 3'b010, d);
    expect_pulse(model_vel(1000), d + LAT);
    edge_after(100, 3'b110, d);
    expect_pulse(model_vel(100), d + LAT);
    edge_after(60, 3'b100, d);
    expect_pulse(model_vel(60), d + LAT);
    check("dir_fwd", direction, 1);

    // Two edges inside one division: only the later period is used.
    edge_after(200, 3'b101, d4);
    expect_pulse(model_vel(200), d4 + LAT);
    edge_after(10, 3'b001, d);
    edge_after(20, 3'b011, d6);
    expect_pulse(model_vel(20), d4 + LAT_PEND);

    // Stall, then restart edge with no pulse, then a saturating measurement.
    expect_pulse(16'd0, d6 + 2 + int'(STALL) + 1);
    edge_after(3100, 3'b010, d);
    edge_after(10, 3'b110, d);
    expect_pulse(model_vel(10), d + LAT);

    // Reverse edge.
    edge_after(100, 3'b010, d);
`ifdef HALL_DIRECTION_EN
    expect_pulse(model_vel(100), d + LAT);
    repeat (99) @(negedge clk);
    check("dir_rev", direction, 0);
    check("fault_rev", hall_fault, 0);
    edge_after(1, 3'b110, d);
    expect_pulse(model_vel(100), d + LAT);
    repeat (50) @(negedge clk);
    check("dir_back_fwd", direction, 1);
`else
    repeat (10) @(negedge clk);
    check("fault_rev", hall_fault, 1);
    check("dir_tied", direction, 1);
    edge_after(90, 3'b110, d);
    repeat (50) @(negedge clk);
`endif

    // Reset clears outputs, then reset in the middle of a division.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset2");
    reset_n = 1'b1;
    edge_after(5, 3'b100, d);
    edge_after(100, 3'b101, d);
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);

    // Illegal code: sticky fault, no pulse, later legal edges still measure.
    edge_after(1, 3'b001, d);
    edge_after(100, 3'b111, d);
    repeat (5) @(negedge clk);
    check("fault_set", hall_fault, 1);
    edge_after(45, 3'b011, d);
    edge_after(200, 3'b010, d);
    expect_pulse(model_vel(200), d + LAT);
    repeat (50) @(negedge clk);
    check("fault_sticky", hall_fault, 1);
    reset_n = 1'b0;
    #1;
    check("fault_cleared", hall_fault, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    check("pulse_count", pulses, pushes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
